whack_game_param: RTL and testbench
===================================

WHACK_GAME_PARAM -- requirements
Module: whack_game_param

Interface
REQ-001 Parameter N_MOLES, default 7: number of mole lamps/buttons, legal 2..16.
REQ-002 Parameter GAME_TICKS, default 60000: game length in enabled cycles, legal 1..65535.
REQ-003 Parameter ROUND_BASE, default 5000: round length at level 0, 16-bit.
REQ-004 Parameter ROUND_STEP, default 1000: round-length reduction per level.
REQ-005 Parameter ROUND_MIN, default 2000: round-length floor.
REQ-006 Parameter LEVEL_PTS, default 5: points per level, legal >=1.
REQ-007 Parameter MAX_LIT, default 4: cap on lit moles per round, legal 1..N_MOLES.
REQ-008 Parameter LIVES, default 3: misses allowed, legal 1..7.
REQ-009 Parameter SCORE_W, default 8: score width.
REQ-010 clk  in  1  sole clock, rising edge.
REQ-011 rst_n  in  1  asynchronous active-low reset.
REQ-012 ena  in  1  cycle enable; low freezes all state except the button sample register.
REQ-013 start  in  1  level; rising edge starts or restarts a game.
REQ-014 btn  in  N_MOLES  synchronised buttons, 1 = pressed.
REQ-015 seed  in  16  LFSR seed captured on start.
REQ-016 pattern  out  N_MOLES  lit moles, 1 = lit.
REQ-017 score  out  SCORE_W  hits this game.
REQ-018 lives_left  out  3  remaining lives.
REQ-019 level  out  3  current difficulty level.
REQ-020 game_over  out  1  high in OVER state.
REQ-021 hit_pulse / miss_pulse  out  1 each  one-cycle event strobes.

Function
REQ-022 States IDLE, ARM, WAIT, HIT, MISS, OVER; each transition takes one enabled cycle.
REQ-023 IDLE/OVER: start rising edge (start=1, previous sample 0) loads LFSR with seed (16'hACE1 if seed==0), game timer=GAME_TICKS, score=0, lives_left=LIVES, -> ARM.
REQ-024 level = min(score / LEVEL_PTS, 7); num_lit = min(level+1, MAX_LIT); round length = max(ROUND_BASE - level*ROUND_STEP, ROUND_MIN), no underflow.
REQ-025 ARM: latch pattern from picker, load round timer, clear hit mask, -> WAIT.
REQ-026 WAIT: rising edges of btn on lit moles OR into hit mask; rising edge on any unlit mole -> MISS; hit mask == pattern -> HIT; round timer reaching 0 -> MISS.
REQ-027 WAIT priority same cycle: wrong press > completion > round expiry.
REQ-028 HIT: score+1 saturating at all-ones, hit_pulse=1, -> ARM.
REQ-029 MISS: lives_left-1, miss_pulse=1; new value 0 -> OVER else -> ARM.
REQ-030 Game timer decrements each enabled cycle in ARM/WAIT/HIT/MISS; at 0 the next state is OVER, taking priority over all WAIT/HIT/MISS exits (score/lives update of that cycle still applied).
REQ-031 pattern = 0 outside ARM/WAIT/HIT/MISS; held buttons at ARM never count (edges only).
REQ-032 LFSR 16-bit Fibonacci, taps 16,14,13,11, shifts every enabled cycle in all states.
REQ-033 Picker: set the lowest num_lit set bits of lfsr[N_MOLES-1:0]; if fewer, fill lowest clear bits from bit 0; output popcount exactly num_lit.
REQ-034 ena low: no state, timer, LFSR, score or strobe change; strobes forced 0; btn/start sample registers still update so no stale edge on re-enable.

Reset
REQ-035 rst_n low: state IDLE, pattern 0, score 0, lives_left LIVES, level 0, game_over 0, strobes 0, LFSR 16'hACE1, timers 0, sample registers 0.
REQ-036 Reset mid-game aborts immediately; no pulse emitted on release.

Structure
REQ-037 Shared package whack_pkg holds state enum and default-parameter constants.
REQ-038 Sub-module mole_pattern_pick (LFSR + picker, parameter N_MOLES) instantiated once.

Verification (N_MOLES=4, GAME_TICKS=200, ROUND_BASE=20, ROUND_STEP=5, ROUND_MIN=10, LEVEL_PTS=2, MAX_LIT=3, LIVES=2)
REQ-039 Reset, start pulse -> ARM next cycle, lives_left=2, score=0, popcount(pattern)=1.
REQ-040 Press exactly the lit mole each round 4 times -> score=4, level=2, popcount=3, round length 10.
REQ-041 Press unlit mole and lit mole same cycle -> miss_pulse, lives_left=1, score unchanged.
REQ-042 No presses for 2 rounds -> two miss_pulses at round expiry, game_over=1, pattern=0.
REQ-043 Play without misses -> OVER exactly 200 enabled cycles after start; ena low 50 cycles mid-game extends by 50.
REQ-044 Score at 255 (SCORE_W=8) plus hit -> stays 255; start edge in OVER restarts with score=0.

Source files
------------

// File: rtl/whack_pkg.sv
// Shared types, default parameter values and the LFSR step for the whack-a-mole game.
package whack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HIT  = 3'd3,
    ST_MISS = 3'd4,
    ST_OVER = 3'd5
  } state_e;

  localparam int DEF_N_MOLES    = 7;
  localparam int DEF_GAME_TICKS = 60000;
  localparam int DEF_ROUND_BASE = 5000;
  localparam int DEF_ROUND_STEP = 1000;
  localparam int DEF_ROUND_MIN  = 2000;
  localparam int DEF_LEVEL_PTS  = 5;
  localparam int DEF_MAX_LIT    = 4;
  localparam int DEF_LIVES      = 3;
  localparam int DEF_SCORE_W    = 8;

  // Value loaded at reset and when a zero seed is supplied (zero would lock up).
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  // One Fibonacci step with taps 16,14,13,11 (bit indices 15,13,12,10).
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

endpackage

// File: rtl/mole_pattern_pick.sv
// Free-running LFSR plus a picker that turns its low bits into a pattern with
// exactly num_lit bits set.
module mole_pattern_pick
  import whack_pkg::*;
#(
  parameter int N_MOLES = DEF_N_MOLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               load,
  input  logic [15:0]        seed,
  input  logic [4:0]         num_lit,
  output logic [N_MOLES-1:0] pick
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [4:0]  cnt_s;

  // Reseed on game start, otherwise advance once per enabled cycle
  always_comb begin
    lfsr_d = lfsr_q;
    if (ena) begin
      if (load) begin
        lfsr_d = (seed == 16'h0000) ? LFSR_INIT : seed;
      end else begin
        lfsr_d = lfsr_next(lfsr_q);
      end
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_INIT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Take the lowest set bits first, then top up with the lowest clear bits
  always_comb begin
    cnt_s = 5'd0;
    pick  = '0;
    for (int i = 0; i < N_MOLES; i++) begin
      if (lfsr_q[i] && (cnt_s < num_lit)) begin
        pick[i] = 1'b1;
        cnt_s   = cnt_s + 5'd1;
      end else begin
        cnt_s = cnt_s;
      end
    end
    for (int i = 0; i < N_MOLES; i++) begin
      if (!lfsr_q[i] && (cnt_s < num_lit)) begin
        pick[i] = 1'b1;
        cnt_s   = cnt_s + 5'd1;
      end else begin
        cnt_s = cnt_s;
      end
    end
  end

endmodule

// File: rtl/whack_game_param.sv
// Whack-a-mole game controller: rounds of lit moles, scoring, lives, levels and
// an overall game timer. All outputs are registered.
module whack_game_param
  import whack_pkg::*;
#(
  parameter int N_MOLES    = DEF_N_MOLES,
  parameter int GAME_TICKS = DEF_GAME_TICKS,
  parameter int ROUND_BASE = DEF_ROUND_BASE,
  parameter int ROUND_STEP = DEF_ROUND_STEP,
  parameter int ROUND_MIN  = DEF_ROUND_MIN,
  parameter int LEVEL_PTS  = DEF_LEVEL_PTS,
  parameter int MAX_LIT    = DEF_MAX_LIT,
  parameter int LIVES      = DEF_LIVES,
  parameter int SCORE_W    = DEF_SCORE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic [N_MOLES-1:0] btn,
  input  logic [15:0]        seed,
  output logic [N_MOLES-1:0] pattern,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives_left,
  output logic [2:0]         level,
  output logic               game_over,
  output logic               hit_pulse,
  output logic               miss_pulse
);

  state_e               state_q, state_d;
  logic [15:0]          game_tmr_q, game_tmr_d;
  logic [15:0]          round_tmr_q, round_tmr_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [2:0]           lives_q, lives_d;
  logic [2:0]           level_q, level_d;
  logic [N_MOLES-1:0]   mask_q, mask_d;
  logic [N_MOLES-1:0]   pattern_q, pattern_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic                 over_q, over_d;
  logic [N_MOLES-1:0]   btn_prev_q;
  logic                 start_prev_q;

  logic [N_MOLES-1:0]   btn_rise_s;
  logic [N_MOLES-1:0]   mask_next_s;
  logic [N_MOLES-1:0]   pick_s;
  logic [4:0]           num_lit_s;
  logic                 start_rise_s;
  logic                 load_s;
  logic                 active_s;

  // Difficulty level from score, capped at 7.
  function automatic logic [2:0] level_of(input logic [SCORE_W-1:0] s);
    int unsigned q;
    q = 32'(s) / LEVEL_PTS;
    return (q > 32'd7) ? 3'd7 : q[2:0];
  endfunction

  // Moles to light this round: level+1, capped at MAX_LIT.
  function automatic logic [4:0] num_lit_of(input logic [2:0] lv);
    int unsigned n;
    n = 32'(lv) + 32'd1;
    if (n > MAX_LIT) begin
      n = MAX_LIT;
    end else begin
      n = n;
    end
    return n[4:0];
  endfunction

  // Round length shrinks with level, never below ROUND_MIN and never wrapping.
  function automatic logic [15:0] round_len_of(input logic [2:0] lv);
    int unsigned rl_sub, rl_len;
    rl_sub = 32'(lv) * ROUND_STEP;
    if (rl_sub < ROUND_BASE) begin
      rl_len = ROUND_BASE - rl_sub;
    end else begin
      rl_len = 32'd0;
    end
    if (rl_len < ROUND_MIN) begin
      rl_len = ROUND_MIN;
    end else begin
      rl_len = rl_len;
    end
    return rl_len[15:0];
  endfunction

  assign btn_rise_s   = btn & ~btn_prev_q;
  assign start_rise_s = start & ~start_prev_q;
  assign mask_next_s  = mask_q | (btn_rise_s & pattern_q);
  assign active_s     = (state_q == ST_ARM) || (state_q == ST_WAIT) ||
                        (state_q == ST_HIT) || (state_q == ST_MISS);
  assign load_s       = ena && start_rise_s &&
                        ((state_q == ST_IDLE) || (state_q == ST_OVER));
  assign num_lit_s    = num_lit_of(level_d);

  mole_pattern_pick #(.N_MOLES(N_MOLES)) u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .load    (load_s),
    .seed    (seed),
    .num_lit (num_lit_s),
    .pick    (pick_s)
  );

  // Next-state and datapath decisions; nothing moves while ena is low
  always_comb begin
    state_d     = state_q;
    game_tmr_d  = game_tmr_q;
    round_tmr_d = round_tmr_q;
    score_d     = score_q;
    lives_d     = lives_q;
    mask_d      = mask_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    if (ena) begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_rise_s) begin
            game_tmr_d = 16'(GAME_TICKS);
            score_d    = '0;
            lives_d    = 3'(LIVES);
            state_d    = ST_ARM;
          end else begin
            state_d = state_q;
          end
        end
        ST_ARM: begin
          round_tmr_d = round_len_of(level_q);
          mask_d      = '0;
          state_d     = ST_WAIT;
        end
        ST_WAIT: begin
          mask_d      = mask_next_s;
          round_tmr_d = (round_tmr_q != 16'd0) ? (round_tmr_q - 16'd1) : 16'd0;
          // A wrong press beats completion, which beats round expiry
          if (|(btn_rise_s & ~pattern_q)) begin
            state_d = ST_MISS;
          end else if (mask_next_s == pattern_q) begin
            state_d = ST_HIT;
          end else if (round_tmr_q <= 16'd1) begin
            state_d = ST_MISS;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_HIT: begin
          score_d = (&score_q) ? score_q : (score_q + SCORE_W'(1));
          hit_d   = 1'b1;
          state_d = ST_ARM;
        end
        ST_MISS: begin
          lives_d = (lives_q != 3'd0) ? (lives_q - 3'd1) : 3'd0;
          miss_d  = 1'b1;
          state_d = (lives_d == 3'd0) ? ST_OVER : ST_ARM;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      // Game timer runs only while playing and its expiry overrides every other exit
      if (active_s) begin
        game_tmr_d = (game_tmr_q != 16'd0) ? (game_tmr_q - 16'd1) : 16'd0;
        if (game_tmr_q <= 16'd1) begin
          state_d = ST_OVER;
        end else begin
          state_d = state_d;
        end
      end else begin
        game_tmr_d = game_tmr_d;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Output-side values derived from the next state so they register in step with it
  always_comb begin
    level_d = level_of(score_d);
    over_d  = (state_d == ST_OVER);
    if (ena && (state_d == ST_ARM)) begin
      pattern_d = pick_s;
    end else if ((state_d == ST_IDLE) || (state_d == ST_OVER)) begin
      pattern_d = '0;
    end else begin
      pattern_d = pattern_q;
    end
  end

  // State and datapath registers; button/start samplers update even when ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      game_tmr_q   <= 16'd0;
      round_tmr_q  <= 16'd0;
      score_q      <= '0;
      lives_q      <= 3'(LIVES);
      level_q      <= 3'd0;
      mask_q       <= '0;
      pattern_q    <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      over_q       <= 1'b0;
      btn_prev_q   <= '0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      game_tmr_q   <= game_tmr_d;
      round_tmr_q  <= round_tmr_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      mask_q       <= mask_d;
      pattern_q    <= pattern_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      over_q       <= over_d;
      btn_prev_q   <= btn;
      start_prev_q <= start;
    end
  end

  assign pattern    = pattern_q;
  assign score      = score_q;
  assign lives_left = lives_q;
  assign level      = level_q;
  assign game_over  = over_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule

// File: tb/tb_whack_game_param.sv
// Directed bench for whack_game_param with the small verification parameter set,
// plus a long-game instance used to drive the score into saturation.
module tb_whack_game_param;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic         start;
  logic         start2;
  logic [N-1:0] btn;
  logic [N-1:0] btn2;
  logic [15:0]  seed;

  logic [N-1:0] pattern, pattern2;
  logic [7:0]   score, score2;
  logic [2:0]   lives_left, lives2;
  logic [2:0]   level, level2;
  logic         game_over, over2;
  logic         hit_pulse, hit2;
  logic         miss_pulse, miss2;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  whack_game_param #(
    .N_MOLES(4), .GAME_TICKS(200), .ROUND_BASE(20), .ROUND_STEP(5), .ROUND_MIN(10),
    .LEVEL_PTS(2), .MAX_LIT(3), .LIVES(2), .SCORE_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .btn(btn), .seed(seed),
    .pattern(pattern), .score(score), .lives_left(lives_left), .level(level),
    .game_over(game_over), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  whack_game_param #(
    .N_MOLES(4), .GAME_TICKS(3000), .ROUND_BASE(20), .ROUND_STEP(5), .ROUND_MIN(10),
    .LEVEL_PTS(2), .MAX_LIT(3), .LIVES(2), .SCORE_W(8)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start2), .btn(btn2), .seed(seed),
    .pattern(pattern2), .score(score2), .lives_left(lives2), .level(level2),
    .game_over(over2), .hit_pulse(hit2), .miss_pulse(miss2)
  );

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; start2 = 1'b0;
    btn = '0; btn2 = '0; seed = 16'h1234;
    repeat (3) @(negedge clk);
    tests_run++; if (pattern !== 4'b0000) begin tests_failed++; $display("FAIL reset_pattern: got %b want %b", pattern, 4'b0000); end
    tests_run++; if (score !== 8'd0) begin tests_failed++; $display("FAIL reset_score: got %0d want 0", score); end
    tests_run++; if (lives_left !== 3'd2) begin tests_failed++; $display("FAIL reset_lives: got %0d want 2", lives_left); end
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", level); end
    tests_run++; if (game_over !== 1'b0) begin tests_failed++; $display("FAIL reset_game_over: got %b want 0", game_over); end
    tests_run++; if ({hit_pulse, miss_pulse} !== 2'b00) begin tests_failed++; $display("FAIL reset_strobes: got %b want 00", {hit_pulse, miss_pulse}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start();
    pulse_start();
    tests_run++; if (lives_left !== 3'd2) begin tests_failed++; $display("FAIL start_lives: got %0d want 2", lives_left); end
    tests_run++; if (score !== 8'd0) begin tests_failed++; $display("FAIL start_score: got %0d want 0", score); end
    tests_run++; if ($countones(pattern) != 1) begin tests_failed++; $display("FAIL start_popcount: got %0d want 1", $countones(pattern)); end
    tests_run++; if (game_over !== 1'b0) begin tests_failed++; $display("FAIL start_game_over: got %b want 0", game_over); end
  endtask

  // Each round: ARM -> WAIT (press lit moles) -> HIT -> ARM with hit_pulse
  task automatic test_hits();
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      btn = pattern;
      @(negedge clk);
      btn = '0;
      @(negedge clk);
      tests_run++; if (hit_pulse !== 1'b1) begin tests_failed++; $display("FAIL hit_pulse_round%0d: got %b want 1", r, hit_pulse); end
    end
    tests_run++; if (score !== 8'd4) begin tests_failed++; $display("FAIL hits_score: got %0d want 4", score); end
    tests_run++; if (level !== 3'd2) begin tests_failed++; $display("FAIL hits_level: got %0d want 2", level); end
    tests_run++; if ($countones(pattern) != 3) begin tests_failed++; $display("FAIL hits_popcount: got %0d want 3", $countones(pattern)); end
  endtask

  // All four buttons at once: the unlit one must win over completion
  task automatic test_wrong_press();
    @(negedge clk);
    btn = 4'b1111;
    @(negedge clk);
    btn = '0;
    @(negedge clk);
    tests_run++; if (miss_pulse !== 1'b1) begin tests_failed++; $display("FAIL wrong_miss_pulse: got %b want 1", miss_pulse); end
    tests_run++; if (lives_left !== 3'd1) begin tests_failed++; $display("FAIL wrong_lives: got %0d want 1", lives_left); end
    tests_run++; if (score !== 8'd4) begin tests_failed++; $display("FAIL wrong_score: got %0d want 4", score); end
  endtask

  // Level 2 round length is 10: ARM + 10 WAIT + MISS, pulse 12 edges after ARM
  task automatic test_round_expiry();
    int got;
    got = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (miss_pulse) begin got = n; break; end
    end
    tests_run++; if (got != 12) begin tests_failed++; $display("FAIL round_len_lvl2: got %0d edges want 12", got); end
    tests_run++; if (game_over !== 1'b1) begin tests_failed++; $display("FAIL expiry_game_over: got %b want 1", game_over); end
    tests_run++; if (pattern !== 4'b0000) begin tests_failed++; $display("FAIL expiry_pattern: got %b want 0000", pattern); end
    tests_run++; if (lives_left !== 3'd0) begin tests_failed++; $display("FAIL expiry_lives: got %0d want 0", lives_left); end
  endtask

  // Restart from OVER with zero seed, then let two level-0 rounds (length 20) expire
  task automatic test_two_misses();
    int first, second;
    first = 0; second = 0;
    seed = 16'h0000;
    pulse_start();
    tests_run++; if (score !== 8'd0) begin tests_failed++; $display("FAIL restart_score: got %0d want 0", score); end
    tests_run++; if (lives_left !== 3'd2) begin tests_failed++; $display("FAIL restart_lives: got %0d want 2", lives_left); end
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (miss_pulse && first == 0) first = n;
      else if (miss_pulse) begin second = n; break; end
    end
    tests_run++; if (first != 22) begin tests_failed++; $display("FAIL miss1_time: got %0d want 22", first); end
    tests_run++; if (second != 44) begin tests_failed++; $display("FAIL miss2_time: got %0d want 44", second); end
    tests_run++; if (game_over !== 1'b1 || pattern !== 4'b0000) begin tests_failed++; $display("FAIL two_miss_over: got over=%b pattern=%b want over=1 pattern=0000", game_over, pattern); end
    seed = 16'h1234;
  endtask

  // Toggling player that never misses; optional 50-cycle ena-low window
  task automatic test_game_length(input int pause_at, input int expect_len, input string tag);
    int got, misses, frozen_bad;
    logic [N-1:0] held;
    got = 0; misses = 0; frozen_bad = 0; held = '0;
    pulse_start();
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (game_over) begin got = n; break; end
      if (miss_pulse) misses++;
      if (pause_at > 0 && n > pause_at && n <= pause_at + 50) begin
        if (pattern !== held || hit_pulse || miss_pulse) frozen_bad++;
      end
      if (pause_at > 0 && n == pause_at) begin ena = 1'b0; held = pattern; end
      if (pause_at > 0 && n == pause_at + 50) ena = 1'b1;
      if (!ena) btn = '0;
      else if (btn != '0) btn = '0;
      else btn = pattern;
    end
    btn = '0;
    ena = 1'b1;
    tests_run++; if (got != expect_len) begin tests_failed++; $display("FAIL %s_length: got %0d want %0d", tag, got, expect_len); end
    tests_run++; if (misses != 0) begin tests_failed++; $display("FAIL %s_misses: got %0d want 0", tag, misses); end
    if (pause_at > 0) begin
      tests_run++; if (frozen_bad != 0) begin tests_failed++; $display("FAIL %s_freeze: got %0d changed cycles want 0", tag, frozen_bad); end
    end
  endtask

  task automatic test_mid_reset();
    int bad;
    bad = 0;
    pulse_start();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++; if (pattern !== 4'b0000 || score !== 8'd0 || lives_left !== 3'd2 || game_over !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_state: got p=%b s=%0d l=%0d o=%b want p=0000 s=0 l=2 o=0", pattern, score, lives_left, game_over); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (hit_pulse || miss_pulse || pattern != 4'b0000) bad++;
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL mid_reset_release: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_saturation();
    int hits_after, misses;
    hits_after = 0; misses = 0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      @(negedge clk);
      if (miss2) misses++;
      if (score2 == 8'd255) break;
      if (btn2 != '0) btn2 = '0;
      else btn2 = pattern2;
    end
    tests_run++; if (score2 !== 8'd255) begin tests_failed++; $display("FAIL sat_reach: got %0d want 255", score2); end
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (miss2) misses++;
      if (hit2) begin
        hits_after++;
        tests_run++; if (score2 !== 8'd255) begin tests_failed++; $display("FAIL sat_hold: got %0d want 255", score2); end
        if (hits_after == 2) break;
      end
      if (btn2 != '0) btn2 = '0;
      else btn2 = pattern2;
    end
    btn2 = '0;
    tests_run++; if (hits_after != 2) begin tests_failed++; $display("FAIL sat_hits_after: got %0d want 2", hits_after); end
    tests_run++; if (level2 !== 3'd7) begin tests_failed++; $display("FAIL sat_level: got %0d want 7", level2); end
    tests_run++; if (misses != 0) begin tests_failed++; $display("FAIL sat_misses: got %0d want 0", misses); end
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (over2) break;
    end
    tests_run++; if (over2 !== 1'b1) begin tests_failed++; $display("FAIL sat_game_over: got %b want 1", over2); end
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    tests_run++; if (score2 !== 8'd0 || lives2 !== 3'd2 || over2 !== 1'b0) begin tests_failed++; $display("FAIL sat_restart: got s=%0d l=%0d o=%b want s=0 l=2 o=0", score2, lives2, over2); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hits();
    test_wrong_press();
    test_round_expiry();
    test_two_misses();
    test_game_length(0, 200, "plain");
    test_game_length(60, 250, "paused");
    test_mid_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
